// File: rtl/puf_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : puf_seq_ctrl                                                 |
// | Description : Challenge sequencer for one RO-PUF bit cell. Walks N_BITS    |
// |               challenges from a seed and assembles the response word.      |
// |               Optional WAIT watchdog enabled by macro PUF_CTRL_TIMEOUT_EN. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module puf_seq_ctrl #(
  parameter int         N_BITS      = 8,
  parameter int         CLR_CYCLES  = 2,
  parameter logic [7:0] CHALL_STEP  = 8'h11
`ifdef PUF_CTRL_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYC = 1023
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        seed,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [N_BITS-1:0] resp_word,
  output logic [7:0]        puf_chall,
  output logic              puf_en,
  output logic              puf_rst,
  input  logic              puf_resp,
  input  logic              puf_finish
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);
  localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic [N_BITS-1:0]   resp_word_q, resp_word_d;
  logic [7:0]          chall_q,     chall_d;
  logic                en_q,        en_d;
  logic                prst_q,      prst_d;
  logic [IDX_W-1:0]    bit_idx_q,   bit_idx_d;
  logic [CLR_W-1:0]    clr_cnt_q,   clr_cnt_d;

`ifdef PUF_CTRL_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC);

  logic [WDOG_W-1:0]   wdog_q,      wdog_d;
  logic                err_q,       err_d;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    resp_word_d = resp_word_q;
    chall_d     = chall_q;
    en_d        = 1'b0;
    prst_d      = 1'b0;
    bit_idx_d   = bit_idx_q;
    clr_cnt_d   = clr_cnt_q;
`ifdef PUF_CTRL_TIMEOUT_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          chall_d     = seed;
          resp_word_d = '0;
          bit_idx_d   = '0;
          clr_cnt_d   = '0;
          busy_d      = 1'b1;
          prst_d      = 1'b1;
          state_d     = S_CLEAR;
`ifdef PUF_CTRL_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end

      S_CLEAR: begin
        if (clr_cnt_q == LAST_CLR) begin
          en_d    = 1'b1;
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
          prst_d    = 1'b1;
        end
      end

      S_RUN: begin
        state_d = S_WAIT;
`ifdef PUF_CTRL_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end

      S_WAIT: begin
        // A finish arriving on the watchdog's last cycle still wins.
        if (puf_finish) begin
          resp_word_d[bit_idx_q] = puf_resp;
          if (bit_idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            chall_d   = chall_q + CHALL_STEP;
            clr_cnt_d = '0;
            prst_d    = 1'b1;
            state_d   = S_CLEAR;
          end
        end
`ifdef PUF_CTRL_TIMEOUT_EN
        else if (wdog_q == WDOG_LIMIT) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resp_word_q <= '0;
      chall_q     <= 8'h00;
      en_q        <= 1'b0;
      prst_q      <= 1'b0;
      bit_idx_q   <= '0;
      clr_cnt_q   <= '0;
`ifdef PUF_CTRL_TIMEOUT_EN
      wdog_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      resp_word_q <= resp_word_d;
      chall_q     <= chall_d;
      en_q        <= en_d;
      prst_q      <= prst_d;
      bit_idx_q   <= bit_idx_d;
      clr_cnt_q   <= clr_cnt_d;
`ifdef PUF_CTRL_TIMEOUT_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign resp_word = resp_word_q;
  assign puf_chall = chall_q;
  assign puf_en    = en_q;
  assign puf_rst   = prst_q;

`ifdef PUF_CTRL_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_puf_seq_ctrl.sv
`default_nettype none
// Bench for puf_seq_ctrl: behavioural PUF cell, expected-value queues, and a
// negedge monitor that scores every enable pulse and every done pulse.
module tb_puf_seq_ctrl;

  localparam int N_BITS     = 8;
  localparam int CLR_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        seed = 8'h00;
  logic              busy, done, err, puf_en, puf_rst;
  logic [N_BITS-1:0] resp_word;
  logic [7:0]        puf_chall;
  logic              puf_resp, puf_finish;

  always #5 clk = ~clk;

  puf_seq_ctrl #(
    .N_BITS     (N_BITS),
    .CLR_CYCLES (CLR_CYCLES),
    .CHALL_STEP (8'h11)
`ifdef PUF_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .resp_word  (resp_word),
    .puf_chall  (puf_chall),
    .puf_en     (puf_en),
    .puf_rst    (puf_rst),
    .puf_resp   (puf_resp),
    .puf_finish (puf_finish)
  );

  typedef struct {
    logic [7:0] word;
    logic       err;
    int         n_en;
  } exp_t;

  logic [7:0] exp_chall_q[$];
  exp_t       exp_word_q[$];

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int en_seen = 0;

  // cell model configuration
  int m_mode = 0;
  int m_dly = 1;
  int m_level = 0;
  int m_skip = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic resp_fn(input int mode, input logic [7:0] c);
    return (mode == 0) ? (c[0] ^ c[4]) : c[1];
  endfunction

  // PUF cell: finish arrives m_dly cycles after the enable pulse
  initial begin : cell_model
    int         cnt;
    int         bitn;
    logic       pend;
    logic [7:0] c;
    puf_finish = 1'b0;
    puf_resp   = 1'b0;
    cnt = 0; bitn = 0; pend = 1'b0; c = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        puf_finish = 1'b0;
        pend = 1'b0;
        bitn = 0;
      end else begin
        if (m_level != 0 && (puf_rst || done)) puf_finish = 1'b0;
        else if (m_level == 0 && puf_finish)   puf_finish = 1'b0;
        if (done) bitn = 0;
        if (puf_en) begin
          c    = puf_chall;
          cnt  = m_dly;
          pend = (bitn != m_skip);
          bitn++;
        end else if (pend) begin
          cnt--;
        end
        if (pend && cnt <= 0) begin
          puf_finish = 1'b1;
          puf_resp   = resp_fn(m_mode, c);
          pend       = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    int         rst_run;
    int         n_en;
    logic       prev_busy, prev_done, prev_en;
    exp_t       e;
    logic [7:0] ec;
    rst_run = 0; n_en = 0; prev_busy = 1'b0; prev_done = 1'b0; prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rst_run = 0; n_en = 0; prev_busy = 1'b0; prev_done = 1'b0; prev_en = 1'b0;
      end else begin
        if (puf_rst) rst_run++;
        if (puf_en) begin
          check("en_width", prev_en, 1'b0);
          check("en_rst_overlap", puf_rst, 1'b0);
          check("rst_cycles_before_en", rst_run, CLR_CYCLES);
          check("busy_at_en", busy, 1'b1);
          if (exp_chall_q.size() == 0) begin
            check("unexpected_en", 0, 1);
          end else begin
            ec = exp_chall_q.pop_front();
            check("puf_chall", puf_chall, ec);
          end
          rst_run = 0;
          n_en++;
          en_seen++;
        end
        if (done) begin
          check("done_one_cycle", prev_done, 1'b0);
          check("busy_at_done", busy, 1'b1);
          if (exp_word_q.size() == 0) begin
            check("unexpected_done", 0, 1);
          end else begin
            e = exp_word_q.pop_front();
            check("resp_word", resp_word, e.word);
            check("err", err, e.err);
            check("en_pulses_per_run", n_en, e.n_en);
          end
          n_en = 0;
          done_seen++;
        end
        if (prev_busy && !busy) check("busy_fall_after_done", prev_done, 1'b1);
        prev_busy = busy;
        prev_done = done;
        prev_en   = puf_en;
      end
    end
  end

  task automatic begin_run(input logic [7:0] s, input int mode, input int dly, input int level,
                           input int skip, input logic [7:0] exp_word, input logic exp_err);
    logic [7:0] c;
    int         n;
    exp_t       e;
    m_mode = mode; m_dly = dly; m_level = level; m_skip = skip;
    n = (skip >= 0) ? skip + 1 : N_BITS;
    c = s;
    for (int i = 0; i < n; i++) begin
      exp_chall_q.push_back(c);
      c = c + 8'h11;
    end
    e.word = exp_word; e.err = exp_err; e.n_en = n;
    exp_word_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_seen <= d0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check("run_completed", (done_seen > d0), 1'b1);
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input logic [7:0] s, input int mode, input int dly, input int level,
                     input int skip, input logic [7:0] exp_word, input logic exp_err);
    int d0;
    d0 = done_seen;
    begin_run(s, mode, dly, level, skip, exp_word, exp_err);
    wait_done(d0);
  endtask

  initial begin : stimulus
    int d0;
    int e0;
    int k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_resp_word", resp_word, 8'h00);
    check("rst_puf_chall", puf_chall, 8'h00);
    check("rst_puf_en", puf_en, 1'b0);
    check("rst_puf_rst", puf_rst, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // T2: seed 00, chall[0]^chall[4] -> all zero; then chall[1] -> CC
    run(8'h00, 0, 1, 0, -1, 8'h00, 1'b0);
    run(8'h00, 1, 1, 0, -1, 8'hCC, 1'b0);
    // T3: wrap F8 -> 09 -> 1A ...
    run(8'hF8, 0, 2, 0, -1, 8'hFF, 1'b0);
    // T4: finish 5 cycles after enable
    run(8'hF8, 1, 5, 0, -1, 8'hCC, 1'b0);
    // finish held high already at WAIT entry
    run(8'h00, 1, 0, 1, -1, 8'hCC, 1'b0);

    // T5: stray start mid-run is ignored, then a fresh run from IDLE
    d0 = done_seen;
    begin_run(8'h5A, 0, 3, 0, -1, 8'h3F, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    seed  = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0);
    run(8'h33, 1, 1, 0, -1, 8'h99, 1'b0);

    // T1: asynchronous reset while waiting on bit 1
    e0 = en_seen;
    begin_run(8'h5A, 0, 20, 0, -1, 8'h3F, 1'b0);
    k = 0;
    while (en_seen < e0 + 2 && k < 500) begin
      @(posedge clk);
      k++;
    end
    check("t1_reached_bit1", (en_seen >= e0 + 2), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_pre_abort_word", resp_word, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("t1_busy", busy, 1'b0);
    check("t1_done", done, 1'b0);
    check("t1_err", err, 1'b0);
    check("t1_resp_word", resp_word, 8'h00);
    check("t1_puf_chall", puf_chall, 8'h00);
    check("t1_puf_en", puf_en, 1'b0);
    check("t1_puf_rst", puf_rst, 1'b0);
    exp_chall_q.delete();
    exp_word_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t1_idle_busy", busy, 1'b0);
    check("t1_idle_puf_rst", puf_rst, 1'b0);
    check("t1_idle_chall", puf_chall, 8'h00);
    run(8'hF8, 0, 1, 0, -1, 8'hFF, 1'b0);

`ifdef PUF_CTRL_TIMEOUT_EN
    // T6: bit 3 never finishes -> watchdog ends the run with err set
    run(8'h00, 1, 3, 0, 3, 8'h04, 1'b1);
    run(8'h00, 1, 1, 0, -1, 8'hCC, 1'b0);
`endif

    check("chall_queue_drained", exp_chall_q.size(), 0);
    check("word_queue_drained", exp_word_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
